// File: rtl/scm_read_port_arbiter.sv
// Round-robin arbiter sharing a multi-read-port, single-write-port SCM register file
// among N_REQ requesters. Read responses are returned on each requester's own channel one cycle after grant.
module scm_read_port_arbiter #(
    parameter int N_REQ      = 4,
    parameter int N_READ     = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [N_REQ-1:0]             req_we_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_wdata_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic [N_REQ-1:0]             resp_valid_o,
    output logic [N_REQ*DATA_WIDTH-1:0]  resp_rdata_o,
    output logic [N_READ-1:0]            rf_read_enable_o,
    output logic [N_READ*ADDR_WIDTH-1:0] rf_read_addr_o,
    input  logic [N_READ*DATA_WIDTH-1:0] rf_read_data_i,
    output logic                         rf_write_enable_o,
    output logic [ADDR_WIDTH-1:0]        rf_write_addr_o,
    output logic [DATA_WIDTH-1:0]        rf_write_data_o
);

    localparam int PTR_W  = (N_REQ  > 1) ? $clog2(N_REQ)  : 1;
    localparam int PORT_W = (N_READ > 1) ? $clog2(N_READ) : 1;

    logic [PTR_W-1:0]            r_rr_ptr;
    logic [N_REQ-1:0]            r_resp_pend;
    logic [PORT_W-1:0]           r_port_q [N_REQ];

    logic [N_REQ-1:0]            w_ready;
    logic [N_REQ-1:0]            w_rd_grant;
    logic [PORT_W-1:0]           w_port_sel [N_REQ];
    logic [PTR_W-1:0]            w_rr_next;
    logic [N_READ-1:0]           w_rd_en;
    logic [N_READ*ADDR_WIDTH-1:0] w_rd_addr;
    logic                        w_wr_en;
    logic [ADDR_WIDTH-1:0]       w_wr_addr;
    logic [DATA_WIDTH-1:0]       w_wr_data;

    always_comb begin : arb
        int idx;
        int n_used;
        int last_s;
        w_ready    = '0;
        w_rd_grant = '0;
        w_rd_en    = '0;
        w_rd_addr  = '0;
        w_wr_en    = 1'b0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        w_rr_next  = r_rr_ptr;
        for (int i = 0; i < N_REQ; i++) w_port_sel[i] = '0;
        idx    = 0;
        n_used = 0;
        last_s = -1;

        for (int s = 0; s < N_REQ; s++) begin
            idx = (int'(r_rr_ptr) + s) % N_REQ;
            if (!w_wr_en && req_valid_i[idx] && req_we_i[idx]) begin
                w_wr_en      = 1'b1;
                w_wr_addr    = req_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
                w_wr_data    = req_wdata_i[idx*DATA_WIDTH +: DATA_WIDTH];
                w_ready[idx] = 1'b1;
                last_s       = s;
            end
        end

        // Readers hitting the address being written this cycle retry next cycle.
        for (int s = 0; s < N_REQ; s++) begin
            idx = (int'(r_rr_ptr) + s) % N_REQ;
            if (n_used < N_READ && req_valid_i[idx] && !req_we_i[idx] &&
                !(w_wr_en && req_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH] == w_wr_addr)) begin
                w_ready[idx]    = 1'b1;
                w_rd_grant[idx] = 1'b1;
                w_port_sel[idx] = PORT_W'(n_used);
                w_rd_en[n_used] = 1'b1;
                w_rd_addr[n_used*ADDR_WIDTH +: ADDR_WIDTH] = req_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
                n_used = n_used + 1;
                if (s > last_s) last_s = s;
            end
        end

        if (last_s >= 0) w_rr_next = PTR_W'((int'(r_rr_ptr) + last_s + 1) % N_REQ);

        if (rst) begin
            w_ready    = '0;
            w_rd_grant = '0;
            w_rd_en    = '0;
            w_rd_addr  = '0;
            w_wr_en    = 1'b0;
            w_wr_addr  = '0;
            w_wr_data  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_resp_pend <= '0;
            for (int i = 0; i < N_REQ; i++) r_port_q[i] <= '0;
        end else begin
            r_rr_ptr    <= w_rr_next;
            r_resp_pend <= w_rd_grant;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_rd_grant[i]) r_port_q[i] <= w_port_sel[i];
            end
        end
    end

    always_comb begin
        resp_valid_o = r_resp_pend;
        resp_rdata_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_resp_pend[i])
                resp_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] =
                    rf_read_data_i[int'(r_port_q[i])*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign req_ready_o       = w_ready;
    assign rf_read_enable_o  = w_rd_en;
    assign rf_read_addr_o    = w_rd_addr;
    assign rf_write_enable_o = w_wr_en;
    assign rf_write_addr_o   = w_wr_addr;
    assign rf_write_data_o   = w_wr_data;

endmodule

// File: tb/tb_scm_read_port_arbiter.sv
// Bench for scm_read_port_arbiter: a 2-read-port instance checked through a response scoreboard,
// plus a 1-read-port instance checked for strict rotation.
module tb_scm_read_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_we;
    logic [19:0]  req_addr;
    logic [127:0] req_wdata;

    logic [3:0]   ready0, resp_valid0;
    logic [127:0] resp_rdata0;
    logic [1:0]   rf_re0;
    logic [9:0]   rf_raddr0;
    logic [63:0]  rf_rd0;
    logic         rf_we0;
    logic [4:0]   rf_waddr0;
    logic [31:0]  rf_wdata0;

    logic [3:0]   ready1, resp_valid1;
    logic [127:0] resp_rdata1;
    logic [0:0]   rf_re1;
    logic [4:0]   rf_raddr1;
    logic [31:0]  rf_rd1;
    logic         rf_we1;
    logic [4:0]   rf_waddr1;
    logic [31:0]  rf_wdata1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] rf_mem [32];
    logic [31:0] shadow [32];

    typedef struct { int cyc; logic [31:0] data; } exp_t;
    exp_t exp_q [4][$];

    always #5 clk = ~clk;

    scm_read_port_arbiter #(.N_REQ(4), .N_READ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(ready0), .resp_valid_o(resp_valid0), .resp_rdata_o(resp_rdata0),
        .rf_read_enable_o(rf_re0), .rf_read_addr_o(rf_raddr0), .rf_read_data_i(rf_rd0),
        .rf_write_enable_o(rf_we0), .rf_write_addr_o(rf_waddr0), .rf_write_data_o(rf_wdata0)
    );

    scm_read_port_arbiter #(.N_REQ(4), .N_READ(1), .ADDR_WIDTH(5), .DATA_WIDTH(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(ready1), .resp_valid_o(resp_valid1), .resp_rdata_o(resp_rdata1),
        .rf_read_enable_o(rf_re1), .rf_read_addr_o(rf_raddr1), .rf_read_data_i(rf_rd1),
        .rf_write_enable_o(rf_we1), .rf_write_addr_o(rf_waddr1), .rf_write_data_o(rf_wdata1)
    );

    initial begin
        for (int a = 0; a < 32; a++) begin
            rf_mem[a] = 32'hA5A5_0000 | a;
            shadow[a] = 32'hA5A5_0000 | a;
        end
        rf_rd0 = '0;
        rf_rd1 = '0;
    end

    // Register file models: read data valid the cycle after enable, write commits at the edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (rf_re0[k]) rf_rd0[k*32 +: 32] <= rf_mem[rf_raddr0[k*5 +: 5]];
        if (rf_we0) rf_mem[rf_waddr0] <= rf_wdata0;
        if (rf_re1[0]) rf_rd1 <= {27'd0, rf_raddr1};
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard for the 2-port instance.
    always @(negedge clk) begin
        logic exp_v;
        exp_t e;
        cyc++;
        if (rst) begin
            for (int i = 0; i < 4; i++) exp_q[i].delete();
            check_val("rst_resp_valid", 64'(resp_valid0), 64'd0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_v = (exp_q[i].size() > 0) && (exp_q[i][0].cyc <= cyc);
                if (exp_v || resp_valid0[i]) begin
                    check_val($sformatf("resp_valid[%0d]", i), 64'(resp_valid0[i]), 64'(exp_v));
                    if (exp_v) begin
                        e = exp_q[i].pop_front();
                        check_val($sformatf("resp_rdata[%0d]", i), 64'(resp_rdata0[i*32 +: 32]), 64'(e.data));
                    end
                end
            end
            for (int i = 0; i < 4; i++)
                if (req_valid[i] && ready0[i] && !req_we[i])
                    exp_q[i].push_back('{cyc + 1, shadow[req_addr[i*5 +: 5]]});
            for (int i = 0; i < 4; i++)
                if (req_valid[i] && ready0[i] && req_we[i])
                    shadow[req_addr[i*5 +: 5]] = req_wdata[i*32 +: 32];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [4:0] a,
                           input logic [31:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*5 +: 5]   = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] pat2 [4];
        logic [3:0] pat1 [6];
        int         pidx;
        pat2 = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        pat1 = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};

        // Reset holds every grant low even with all requesters valid.
        rst       = 1'b1;
        req_valid = 4'hF;
        req_we    = 4'b0001;
        req_addr  = '0;
        req_wdata = '0;
        @(negedge clk);
        check_val("rst_ready", 64'(ready0), 64'd0);
        check_val("rst_rd_en", 64'(rf_re0), 64'd0);
        check_val("rst_wr_en", 64'(rf_we0), 64'd0);
        req_valid = '0;
        req_we    = '0;
        step();
        rst = 1'b0;

        // Single read: req2, addr 5, served on port 0.
        set_req(2, 1'b1, 1'b0, 5'd5, 32'd0);
        @(negedge clk);
        check_val("single_ready", 64'(ready0), 64'b0100);
        check_val("single_rd_en", 64'(rf_re0), 64'b01);
        check_val("single_rd_addr0", 64'(rf_raddr0[4:0]), 64'd5);
        step();
        req_valid = '0;
        step();
        step();

        // Full contention: everyone reads every cycle.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 5'(8 + i), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val($sformatf("contend_ready_c%0d", k), 64'(ready0), 64'(pat2[k]));
            step();
        end
        req_valid = '0;
        step();
        step();

        // Write/read conflict on addr 3.
        do_reset();
        set_req(0, 1'b1, 1'b1, 5'd3, 32'h0000_1234);
        set_req(1, 1'b1, 1'b0, 5'd3, 32'd0);
        @(negedge clk);
        check_val("conflict_ready_t", 64'(ready0), 64'b0001);
        check_val("conflict_wr_en", 64'(rf_we0), 64'd1);
        check_val("conflict_wr_addr", 64'(rf_waddr0), 64'd3);
        check_val("conflict_wr_data", 64'(rf_wdata0), 64'h1234);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_val("conflict_ready_t1", 64'(ready0), 64'b0010);
        step();
        req_valid = '0;
        step();
        step();

        // Two writers plus two readers.
        do_reset();
        set_req(0, 1'b1, 1'b0, 5'd10, 32'd0);
        set_req(1, 1'b1, 1'b1, 5'd7,  32'h7777_0001);
        set_req(2, 1'b1, 1'b0, 5'd11, 32'd0);
        set_req(3, 1'b1, 1'b1, 5'd9,  32'h9999_0003);
        @(negedge clk);
        check_val("mix_ready_t", 64'(ready0), 64'b0111);
        check_val("mix_wr_addr_t", 64'(rf_waddr0), 64'd7);
        check_val("mix_rd_addr_t", 64'(rf_raddr0), 64'({5'd11, 5'd10}));
        step();
        set_req(1, 1'b1, 1'b1, 5'd7, 32'h7777_0002);
        @(negedge clk);
        check_val("mix_ready_t1", 64'(ready0), 64'b1101);
        check_val("mix_wr_addr_t1", 64'(rf_waddr0), 64'd9);
        check_val("mix_wr_data_t1", 64'(rf_wdata0), 64'h9999_0003);
        step();
        req_valid = '0;
        step();
        step();

        // Reset asserted the cycle after a read grant.
        do_reset();
        set_req(0, 1'b1, 1'b0, 5'd4, 32'd0);
        @(negedge clk);
        check_val("midrst_ready", 64'(ready0), 64'b0001);
        step();
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        check_val("midrst_resp_valid", 64'(resp_valid0), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 5'(12 + i), 32'd0);
        @(negedge clk);
        check_val("midrst_rr_ptr0", 64'(ready0), 64'b0011);
        step();
        req_valid = '0;
        step();
        step();

        // One read port: three readers served strictly in rotation.
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 5'(20 + i), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val($sformatf("nr1_ready_c%0d", k), 64'(ready1), 64'(pat1[k]));
            check_val($sformatf("nr1_rd_en_c%0d", k), 64'(rf_re1), 64'd1);
            if (k > 0) begin
                pidx = (k - 1) % 3;
                check_val($sformatf("nr1_resp_valid_c%0d", k), 64'(resp_valid1), 64'(pat1[k-1]));
                check_val($sformatf("nr1_resp_rdata_c%0d", k), 64'(resp_rdata1[pidx*32 +: 32]),
                          64'(20 + pidx));
            end
            step();
        end
        req_valid = '0;
        step();
        step();
        step();

        for (int i = 0; i < 4; i++) begin
            if (exp_q[i].size() != 0)
                check_val($sformatf("leftover_resp[%0d]", i), 64'(exp_q[i].size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
